// File: rtl/vending_controller_n.sv
// Vending machine controller: accumulates coin credit, vends a selected
// product when credit covers its price, and holds the remaining credit as
// change until it is collected. All outputs come straight from flops.
module vending_controller_n #(
  parameter int                         CRED_W     = 8,
  parameter int                         NUM_PROD   = 4,
  parameter int                         SEL_W      = 2,
  parameter logic [NUM_PROD*CRED_W-1:0] PRICES     = {8'd40, 8'd30, 8'd25, 8'd20},
  parameter int                         MAX_CREDIT = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [CRED_W-1:0] coin_val,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel_id,
  input  logic              cancel,
  input  logic              change_ack,
  output logic              dispense,
  output logic [SEL_W-1:0]  dispense_id,
  output logic              change_valid,
  output logic [CRED_W-1:0] change_amt,
  output logic              coin_reject,
  output logic              sel_error,
  output logic [CRED_W-1:0] credit,
  output logic [1:0]        current_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CREDIT = 2'b01,
    S_CHANGE = 2'b10,
    S_VEND   = 2'b11
  } state_t;

  localparam int            NUM_SLOTS = 2 ** SEL_W;
  localparam logic [CRED_W:0] MAX_SUM = (CRED_W + 1)'(MAX_CREDIT);

  state_t            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W-1:0] change_amt_q, change_amt_d;
  logic [SEL_W-1:0]  dispense_id_q, dispense_id_d;
  logic              dispense_q, dispense_d;
  logic              change_valid_q, change_valid_d;
  logic              coin_reject_q, coin_reject_d;
  logic              sel_error_q, sel_error_d;

  // Price lookup covering every encodable select value; slots beyond
  // NUM_PROD are flagged unknown so they always produce a selection error.
  logic [CRED_W-1:0]    price_tab [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] sel_known;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_price
      if (gi < NUM_PROD) begin : g_real
        assign price_tab[gi] = PRICES[gi*CRED_W +: CRED_W];
        assign sel_known[gi] = 1'b1;
      end else begin : g_none
        assign price_tab[gi] = '0;
        assign sel_known[gi] = 1'b0;
      end
    end
  endgenerate

  // Zero-value coins are treated as if no coin arrived at all.
  logic              coin_live;
  logic [CRED_W:0]   coin_sum;
  logic              coin_fits;
  logic              sel_ok;

  assign coin_live = coin_valid && (coin_val != '0);
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits = (coin_sum <= MAX_SUM);
  assign sel_ok    = sel_known[sel_id] && (credit_q >= price_tab[sel_id]);

  // Next-state and next-output computation; pulses default low every cycle.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_amt_d   = change_amt_q;
    change_valid_d = change_valid_q;
    dispense_id_d  = '0;
    dispense_d     = 1'b0;
    coin_reject_d  = 1'b0;
    sel_error_d    = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel && (state_q == S_CREDIT)) begin
          // Refund wins over everything; a coin in the same cycle goes back.
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          coin_reject_d  = coin_live;
        end else if (sel_valid && sel_ok) begin
          // Accepted selection; a coin in the same cycle goes back.
          credit_d      = credit_q - price_tab[sel_id];
          dispense_d    = 1'b1;
          dispense_id_d = sel_id;
          state_d       = S_VEND;
          coin_reject_d = coin_live;
        end else begin
          sel_error_d = sel_valid;
          if (coin_live) begin
            if (coin_fits) begin
              credit_d = coin_sum[CRED_W-1:0];
              state_d  = S_CREDIT;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end

      S_VEND: begin
        // Single vend cycle; leftover credit becomes owed change.
        coin_reject_d = coin_live;
        if (credit_q != '0) begin
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHANGE: begin
        // Hold the change offer until the customer collects it.
        coin_reject_d = coin_live;
        if (change_ack) begin
          credit_d       = '0;
          change_valid_d = 1'b0;
          change_amt_d   = '0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any vend or owed change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      change_amt_q   <= '0;
      change_valid_q <= 1'b0;
      dispense_id_q  <= '0;
      dispense_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      change_valid_q <= change_valid_d;
      dispense_id_q  <= dispense_id_d;
      dispense_q     <= dispense_d;
      coin_reject_q  <= coin_reject_d;
      sel_error_q    <= sel_error_d;
    end
  end

  assign dispense      = dispense_q;
  assign dispense_id   = dispense_id_q;
  assign change_valid  = change_valid_q;
  assign change_amt    = change_amt_q;
  assign coin_reject   = coin_reject_q;
  assign sel_error     = sel_error_q;
  assign credit        = credit_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_vending_controller_n.sv
// Scoreboard bench for vending_controller_n with default parameters
// (prices: id0=20, id1=25, id2=30, id3=40; ceiling 100).
module tb_vending_controller_n;

  localparam int EV_DISP = 0;
  localparam int EV_REJ  = 1;
  localparam int EV_SERR = 2;
  localparam int EV_CHG  = 3;

  typedef struct {
    int kind;
    int val;
    int cred;
    int st;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_val = 8'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic       sel_error;
  logic [7:0] credit;
  logic [1:0] current_state;

  int   vectors = 0;
  int   miscompares = 0;
  ev_t  sb[$];
  logic cv_prev = 1'b0;

  vending_controller_n dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .coin_reject  (coin_reject),
    .sel_error    (sel_error),
    .credit       (credit),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      EV_DISP: return "dispense";
      EV_REJ:  return "coin_reject";
      EV_SERR: return "sel_error";
      default: return "change";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic expect_ev(input int k, input int v, input int c, input int s);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cred = c;
    e.st   = s;
    sb.push_back(e);
  endtask

  // Compare one observed output event against the head of the scoreboard.
  task automatic see(input int k, input int v);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s val=%0d credit=%0d state=%0d, expected no event",
               kname(k), v, credit, current_state);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v || e.cred != int'(credit) || e.st != int'(current_state)) begin
        miscompares++;
        $display("FAIL event: got %s val=%0d credit=%0d state=%0d, expected %s val=%0d credit=%0d state=%0d",
                 kname(k), v, credit, current_state, kname(e.kind), e.val, e.cred, e.st);
      end else begin
        $display("ok   event %s val=%0d credit=%0d state=%0d", kname(k), v, credit, current_state);
      end
    end
  endtask

  // Monitor: samples just after each rising edge, independent of stimulus.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (dispense)                 see(EV_DISP, int'(dispense_id));
      if (coin_reject)              see(EV_REJ, 0);
      if (sel_error)                see(EV_SERR, 0);
      if (change_valid && !cv_prev) see(EV_CHG, int'(change_amt));
    end
    cv_prev = change_valid;
  end

  // Drive one cycle of inputs starting at a falling edge, then clear them.
  task automatic cyc(input logic cv, input int cval, input logic sv, input int sid,
                     input logic can, input logic ack);
    coin_valid = cv;
    coin_val   = 8'(cval);
    sel_valid  = sv;
    sel_id     = 2'(sid);
    cancel     = can;
    change_ack = ack;
    @(negedge clk);
    coin_valid = 1'b0;
    coin_val   = 8'd0;
    sel_valid  = 1'b0;
    sel_id     = 2'd0;
    cancel     = 1'b0;
    change_ack = 1'b0;
  endtask

  task automatic coin(input int v);
    cyc(1'b1, v, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic sel(input int id);
    cyc(1'b0, 0, 1'b1, id, 1'b0, 1'b0);
  endtask

  task automatic do_cancel();
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic do_ack();
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(current_state), 0);
    chk({tag, "_credit"}, int'(credit), 0);
    chk({tag, "_dispense"}, int'(dispense), 0);
    chk({tag, "_dispense_id"}, int'(dispense_id), 0);
    chk({tag, "_change_valid"}, int'(change_valid), 0);
    chk({tag, "_change_amt"}, int'(change_amt), 0);
    chk({tag, "_coin_reject"}, int'(coin_reject), 0);
    chk({tag, "_sel_error"}, int'(sel_error), 0);
  endtask

  initial begin
    // Reset takes effect without a clock edge.
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Exact-price vend, no change owed.
    coin(10);
    chk("credit_after_10", int'(credit), 10);
    chk("state_credit", int'(current_state), 1);
    coin(10);
    chk("credit_after_20", int'(credit), 20);
    expect_ev(EV_DISP, 0, 0, 3);
    sel(0);
    chk("state_vend", int'(current_state), 3);
    @(negedge clk);
    chk("idle_after_vend", int'(current_state), 0);
    chk("no_change_after_exact", int'(change_valid), 0);

    // Vend with change (product 2 costs 30), change held until collected.
    coin(20);
    coin(20);
    chk("credit_40", int'(credit), 40);
    expect_ev(EV_DISP, 2, 10, 3);
    expect_ev(EV_CHG, 10, 10, 2);
    sel(2);
    repeat (5) @(negedge clk);
    chk("change_held_valid", int'(change_valid), 1);
    chk("change_held_amt", int'(change_amt), 10);
    chk("change_held_state", int'(current_state), 2);
    do_ack();
    chk("ack_change_valid", int'(change_valid), 0);
    chk("ack_state", int'(current_state), 0);
    chk("ack_credit", int'(credit), 0);

    // Credit ceiling: 90+20 refused, 90+10 lands exactly on 100, then +5 refused.
    coin(50);
    coin(40);
    expect_ev(EV_REJ, 0, 90, 1);
    coin(20);
    chk("credit_stays_90", int'(credit), 90);
    coin(10);
    chk("credit_at_max", int'(credit), 100);
    expect_ev(EV_REJ, 0, 100, 1);
    coin(5);
    expect_ev(EV_CHG, 100, 100, 2);
    do_cancel();
    do_ack();

    // Insufficient credit for product 3, then exact credit for product 2.
    coin(20);
    coin(10);
    expect_ev(EV_SERR, 0, 30, 1);
    sel(3);
    chk("credit_stays_30", int'(credit), 30);
    chk("state_after_selerr", int'(current_state), 1);
    expect_ev(EV_DISP, 2, 0, 3);
    sel(2);
    @(negedge clk);
    chk("idle_after_exact30", int'(current_state), 0);

    // Cancel, coin and selection in one cycle: cancel wins, coin refused.
    coin(25);
    expect_ev(EV_REJ, 0, 25, 2);
    expect_ev(EV_CHG, 25, 25, 2);
    cyc(1'b1, 5, 1'b1, 0, 1'b1, 1'b0);
    chk("cancel_state", int'(current_state), 2);
    chk("cancel_amt", int'(change_amt), 25);
    do_ack();

    // Inputs that must be ignored in IDLE.
    do_cancel();
    chk("idle_cancel_ignored", int'(current_state), 0);
    coin(0);
    chk("zero_coin_state", int'(current_state), 0);
    chk("zero_coin_credit", int'(credit), 0);
    do_ack();
    chk("idle_ack_ignored", int'(current_state), 0);

    // Coin during VEND refused; selection and cancel during CHANGE ignored.
    coin(40);
    expect_ev(EV_DISP, 1, 15, 3);
    expect_ev(EV_REJ, 0, 15, 2);
    expect_ev(EV_CHG, 15, 15, 2);
    sel(1);
    coin(5);
    sel(0);
    do_cancel();
    chk("change_state_kept", int'(current_state), 2);
    chk("change_amt_15", int'(change_amt), 15);
    do_ack();

    // Reset during a CHANGE wait clears everything at once.
    coin(30);
    expect_ev(EV_CHG, 30, 30, 2);
    do_cancel();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("midchange_reset");
    @(negedge clk);
    rst = 1'b1;
    coin(10);
    chk("post_reset_credit", int'(credit), 10);
    chk("post_reset_state", int'(current_state), 1);
    expect_ev(EV_CHG, 10, 10, 2);
    do_cancel();
    do_ack();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", int'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
